instruction_sequencer: RTL and testbench

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/instruction_sequencer.sv | 137 +++++++++++++
 tb/tb_instruction_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// Fetches 16-bit instruction words from a synchronous memory and issues them one at a time to the control unit.
// Multi-cycle ops are held in WAIT until op_done arrives; a bounded wait ends in a sticky timeout error.
module instruction_sequencer #(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [PC_W-1:0] start_pc,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd_en,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     instruction,
  input  logic            op_done,
  output logic            busy,
  output logic            halted,
  output logic            error,
  output logic [15:0]     instr_count
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_WAIT    = 3'd4;
  localparam logic [2:0] ST_HALTED  = 3'd5;

  localparam logic [2:0]  OP_HALT     = 3'b111;
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  logic [2:0]      state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [15:0]     instr_reg, instr_next;
  logic [15:0]     count_reg, count_next;
  logic [15:0]     wait_reg, wait_next;
  logic            error_reg, error_next;

  logic [2:0]  exec_op;
  logic        exec_multi;
  logic [15:0] wait_inc;

  assign exec_op    = instr_reg[15:13];
  assign exec_multi = (exec_op == 3'b010) || (exec_op == 3'b011) ||
                      (exec_op == 3'b100) || (exec_op == 3'b101);
  assign wait_inc   = wait_reg + 16'd1;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    count_next = count_reg;
    wait_next  = wait_reg;
    error_next = error_reg;
    case (state_reg)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          pc_next    = start_pc;
          count_next = 16'd0;
          error_next = 1'b0;
          wait_next  = 16'd0;
          instr_next = 16'h0000;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // HALT is never presented to the control unit but still counts as retired
        if (imem_rdata[15:13] == OP_HALT) begin
          count_next = count_reg + 16'd1;
          state_next = ST_HALTED;
        end else begin
          instr_next = imem_rdata;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        instr_next = 16'h0000;
        if (!exec_multi || op_done) begin
          pc_next    = pc_reg + PC_W'(1);
          count_next = count_reg + 16'd1;
          state_next = ST_FETCH;
        end else begin
          wait_next  = 16'd0;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // a completion arriving on the last allowed cycle still wins over the timeout
        if (op_done) begin
          pc_next    = pc_reg + PC_W'(1);
          count_next = count_reg + 16'd1;
          state_next = ST_FETCH;
        end else begin
          wait_next = wait_inc;
          if (wait_inc == TIMEOUT_CNT) begin
            error_next = 1'b1;
            state_next = ST_HALTED;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      pc_reg    <= '0;
      instr_reg <= 16'h0000;
      count_reg <= 16'd0;
      wait_reg  <= 16'd0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      count_reg <= count_next;
      wait_reg  <= wait_next;
      error_reg <= error_next;
    end
  end

  assign imem_addr   = pc_reg;
  assign imem_rd_en  = (state_reg == ST_FETCH);
  assign instruction = instr_reg;
  assign busy        = (state_reg == ST_FETCH) || (state_reg == ST_CAPTURE) ||
                       (state_reg == ST_EXEC)  || (state_reg == ST_WAIT);
  assign halted      = (state_reg == ST_HALTED);
  assign error       = error_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench: a program-level reference model queues expected fetches and issued words;
// independent monitor and op_done driver processes react to the sequencer at the falling edge.
module tb_instruction_sequencer;
  localparam int PC_W = 8;
  localparam int TMO  = 6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  start_pc;
  logic [7:0]  imem_addr;
  logic        imem_rd_en;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] instruction;
  logic        op_done = 1'b0;
  logic        busy, halted, error;
  logic [15:0] instr_count;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [256];
  logic [7:0]  fetch_q [$];
  logic [15:0] instr_q [$];
  int          kq [$];
  int          plan [$];

  always #5 clk = ~clk;

  instruction_sequencer #(.PC_W(PC_W), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_pc   (start_pc),
    .imem_addr  (imem_addr),
    .imem_rd_en (imem_rd_en),
    .imem_rdata (imem_rdata),
    .instruction(instruction),
    .op_done    (op_done),
    .busy       (busy),
    .halted     (halted),
    .error      (error),
    .instr_count(instr_count)
  );

  // synchronous instruction memory: data one cycle after the strobe
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=0x%0h expected=none", name, act);
  endtask

  // monitor: every fetch strobe and every issued word is matched against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (imem_rd_en) begin
          if (fetch_q.size() == 0) unexpected("fetch_unexpected", {24'd0, imem_addr});
          else chk("fetch_addr", {24'd0, imem_addr}, {24'd0, fetch_q.pop_front()});
        end
        if (instruction != 16'h0000) begin
          if (instr_q.size() == 0) unexpected("instr_unexpected", {16'd0, instruction});
          else chk("instr_word", {16'd0, instruction}, {16'd0, instr_q.pop_front()});
        end
      end
    end
  end

  // datapath stand-in: k = number of WAIT cycles before op_done, -1 = never
  initial begin
    int od_cnt;
    int k;
    od_cnt = -1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        od_cnt  = -1;
        op_done = 1'b0;
      end else begin
        op_done = 1'b0;
        if (od_cnt > 0) begin
          od_cnt--;
          if (od_cnt == 0) op_done = 1'b1;
        end
        if (instruction[15:13] inside {3'd2, 3'd3, 3'd4, 3'd5}) begin
          if (kq.size() == 0) unexpected("multi_unexpected", {16'd0, instruction});
          else begin
            k = kq.pop_front();
            if (k == 0) op_done = 1'b1;
            else if (k > 0) od_cnt = k;
          end
        end
      end
    end
  end

  // reference model: walk the program, 3 cycles per op, +k waits, HALT costs 2 and retires
  task automatic model(input logic [7:0] spc, output int cyc, output int cnt, output bit err);
    logic [7:0]  pc;
    logic [15:0] w;
    logic [2:0]  op;
    int k;
    int r;
    pc = spc; cyc = 0; cnt = 0; err = 1'b0;
    for (int step = 0; step < 400; step++) begin
      fetch_q.push_back(pc);
      w  = mem[pc];
      op = w[15:13];
      if (op == 3'd7) begin
        cnt++;
        cyc += 2;
        break;
      end
      if (w != 16'h0000) instr_q.push_back(w);
      if (op >= 3'd2 && op <= 3'd5) begin
        if (plan.size() > 0) k = plan.pop_front();
        else begin
          r = int'($urandom_range(0, 11));
          k = (r == 0) ? -1 : (r % TMO);
        end
        kq.push_back(k);
        if (k < 0) begin
          err = 1'b1;
          cyc += 3 + TMO;
          break;
        end
        cyc += 3 + k;
      end else begin
        cyc += 3;
      end
      cnt++;
      pc = pc + 8'd1;
    end
  endtask

  task automatic flush();
    fetch_q.delete();
    instr_q.delete();
    kq.delete();
    plan.delete();
  endtask

  task automatic check_reset(input string name);
    chk({name, ":imem_addr"}, {24'd0, imem_addr}, 32'd0);
    chk({name, ":imem_rd_en"}, {31'd0, imem_rd_en}, 32'd0);
    chk({name, ":instruction"}, {16'd0, instruction}, 32'd0);
    chk({name, ":busy"}, {31'd0, busy}, 32'd0);
    chk({name, ":halted"}, {31'd0, halted}, 32'd0);
    chk({name, ":error"}, {31'd0, error}, 32'd0);
    chk({name, ":instr_count"}, {16'd0, instr_count}, 32'd0);
  endtask

  task automatic run_prog(input logic [7:0] spc, input bit ign, input string name);
    int exp_cyc, exp_cnt, n, ign_at;
    bit exp_err;
    model(spc, exp_cyc, exp_cnt, exp_err);
    ign_at = ign ? int'($urandom_range(1, exp_cyc)) : -1;
    @(negedge clk);
    start = 1'b1; start_pc = spc;
    @(negedge clk);
    start = 1'b0; start_pc = 8'($urandom);
    n = 1;
    chk({name, ":start_error"}, {31'd0, error}, 32'd0);
    chk({name, ":start_busy"}, {31'd0, busy}, 32'd1);
    chk({name, ":start_count"}, {16'd0, instr_count}, 32'd0);
    while (!halted && n < 3000) begin
      if (n == ign_at) begin
        start = 1'b1; start_pc = 8'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    chk({name, ":halted"}, {31'd0, halted}, 32'd1);
    chk({name, ":halt_cycle"}, n, exp_cyc + 1);
    chk({name, ":error"}, {31'd0, error}, {31'd0, exp_err});
    chk({name, ":instr_count"}, {16'd0, instr_count}, exp_cnt);
    chk({name, ":busy"}, {31'd0, busy}, 32'd0);
    chk({name, ":fetch_left"}, fetch_q.size(), 32'd0);
    chk({name, ":instr_left"}, instr_q.size(), 32'd0);
    $display("run %s start_pc=%02h cycles=%0d count=%0d error=%0d", name, spc, n - 1, instr_count, error);
    flush();
  endtask

  task automatic reset_mid(input logic [7:0] spc, input int at, input string name);
    int c, e, d;
    bit r;
    model(spc, c, e, r);
    @(negedge clk);
    start = 1'b1; start_pc = spc;
    @(negedge clk);
    start = 1'b0;
    repeat (at - 1) @(negedge clk);
    chk({name, ":busy_before"}, {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1 check_reset(name);
    flush();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk({name, ":idle_busy"}, {31'd0, busy}, 32'd0);
    chk({name, ":idle_rd_en"}, {31'd0, imem_rd_en}, 32'd0);
    chk({name, ":idle_halted"}, {31'd0, halted}, 32'd0);
    $display("run %s reset at cycle %0d", name, at);
    d = c;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  spc, a;
    logic [12:0] lo;
    logic [2:0]  op;
    int len;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    reset_n = 1'b1; start = 1'b0; start_pc = 8'd0;
    #1 reset_n = 1'b0;
    #2 check_reset("reset_async");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_reset:busy", {31'd0, busy}, 32'd0);
    chk("idle_after_reset:rd_en", {31'd0, imem_rd_en}, 32'd0);

    mem[8'h00] = 16'h2005; mem[8'h01] = 16'h0000; mem[8'h02] = 16'hE000;
    run_prog(8'h00, 1'b0, "load_nop_halt");

    mem[8'h20] = 16'h4000; mem[8'h21] = 16'hE000;
    plan.push_back(5);
    run_prog(8'h20, 1'b0, "weight_wait5");

    mem[8'h30] = 16'h8000; mem[8'h31] = 16'hE000;
    plan.push_back(-1);
    run_prog(8'h30, 1'b0, "valid_timeout");

    mem[8'hFF] = 16'h0000; mem[8'h00] = 16'hE000;
    run_prog(8'hFF, 1'b0, "pc_wrap");

    mem[8'h40] = 16'hA000; mem[8'h41] = 16'hE000;
    plan.push_back(0);
    run_prog(8'h40, 1'b0, "store_done_in_exec");

    mem[8'h50] = 16'h4000; mem[8'h51] = 16'hE000;
    plan.push_back(-1);
    reset_mid(8'h50, 4, "reset_in_wait");
    mem[8'h60] = 16'h2001; mem[8'h61] = 16'hE000;
    run_prog(8'h60, 1'b0, "resume_after_reset");

    plan.push_back(-1);
    reset_mid(8'h50, 3, "reset_in_exec");

    for (int t = 0; t < 30; t++) begin
      spc = 8'($urandom);
      if ($urandom_range(0, 3) == 0) spc = 8'hF8 + 8'($urandom_range(0, 7));
      len = int'($urandom_range(0, 10));
      for (int i = 0; i < len; i++) begin
        op = 3'($urandom_range(0, 6));
        lo = ($urandom_range(0, 3) == 0) ? 13'd0 : 13'($urandom);
        a  = spc + 8'(i);
        mem[a] = {op, lo};
      end
      a = spc + 8'(len);
      mem[a] = {3'b111, 13'($urandom)};
      run_prog(spc, 1'($urandom_range(0, 1)), $sformatf("random%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
